// File: rtl/vc_class_allocator.sv
// Separable input-first VC allocator with per-class VC matching, round-robin
// arbitration at both stages and age-based urgency for starving requesters.
module vc_class_allocator #(
    parameter int PORT_NUM   = 5,
    parameter int VC_NUM     = 4,
    parameter int CLASS_NUM  = 2,
    parameter int AGE_MAX    = 3,
    parameter int VC_TOTAL   = PORT_NUM * VC_NUM,
    parameter int VC_SIZE    = $clog2(VC_NUM),
    parameter int CLASS_SIZE = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1,
    parameter int AGE_SIZE   = $clog2(AGE_MAX + 1),
    parameter int PORT_SIZE  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [VC_TOTAL-1:0]                  idle_downstream_vc_i,
    input  logic [VC_TOTAL-1:0]                  vc_to_allocate_i,
    input  logic [VC_TOTAL-1:0][PORT_SIZE-1:0]   out_port_i,
    input  logic [VC_TOTAL-1:0][CLASS_SIZE-1:0]  vc_class_i,
    output logic [VC_TOTAL-1:0][VC_SIZE-1:0]     vc_new_o,
    output logic [VC_TOTAL-1:0]                  vc_valid_o,
    output logic [VC_TOTAL-1:0]                  available_vc_o
);

    localparam int VC_PER_CLASS = VC_NUM / CLASS_NUM;
    localparam int PTR_SIZE     = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1;
    localparam logic [AGE_SIZE-1:0] AGE_URGENT = AGE_SIZE'(AGE_MAX);

    logic [VC_TOTAL-1:0]                avail_reg, avail_next;
    logic [VC_TOTAL-1:0][PTR_SIZE-1:0]  in_ptr_reg, in_ptr_next;
    logic [VC_TOTAL-1:0][PTR_SIZE-1:0]  out_ptr_reg, out_ptr_next;
    logic [VC_TOTAL-1:0][AGE_SIZE-1:0]  age_reg, age_next;

    logic [VC_TOTAL-1:0][VC_TOTAL-1:0]  req;
    logic [VC_TOTAL-1:0]                urgent;
    logic [VC_TOTAL-1:0]                in_hit;
    logic [VC_TOTAL-1:0][PTR_SIZE-1:0]  in_sel;
    logic [VC_TOTAL-1:0]                out_hit;
    logic [VC_TOTAL-1:0][PTR_SIZE-1:0]  out_sel;
    logic [VC_TOTAL-1:0]                gnt_valid;
    logic [VC_TOTAL-1:0][PTR_SIZE-1:0]  gnt_d;

    // Request matrix: an out-of-range port or class simply matches no column.
    for (genvar gi = 0; gi < VC_TOTAL; gi++) begin : g_req_row
        for (genvar gj = 0; gj < VC_TOTAL; gj++) begin : g_req_col
            localparam int PORT_OF_D  = gj / VC_NUM;
            localparam int CLASS_OF_D = (gj % VC_NUM) / VC_PER_CLASS;
            assign req[gi][gj] = vc_to_allocate_i[gi] & avail_reg[gj]
                               & (int'(out_port_i[gi]) == PORT_OF_D)
                               & (int'(vc_class_i[gi]) == CLASS_OF_D);
        end
        assign urgent[gi] = (age_reg[gi] == AGE_URGENT);
    end

    // Input stage: each upstream VC picks one downstream candidate.
    for (genvar gi = 0; gi < VC_TOTAL; gi++) begin : g_in_arb
        logic                hit;
        logic [PTR_SIZE-1:0] sel;
        always_comb begin
            logic [PTR_SIZE-1:0] idx;
            hit = 1'b0;
            sel = '0;
            idx = '0;
            for (int k = 0; k < VC_TOTAL; k++) begin
                idx = PTR_SIZE'((int'(in_ptr_reg[gi]) + k) % VC_TOTAL);
                if (!hit && req[gi][idx]) begin
                    hit = 1'b1;
                    sel = idx;
                end
            end
        end
        assign in_hit[gi] = hit;
        assign in_sel[gi] = sel;
    end

    // Output stage: each downstream VC picks one requester, urgent ones first.
    for (genvar gi = 0; gi < VC_TOTAL; gi++) begin : g_out_arb
        logic                hit;
        logic [PTR_SIZE-1:0] sel;
        always_comb begin
            logic [PTR_SIZE-1:0] idx;
            logic [VC_TOTAL-1:0] cand;
            logic [VC_TOTAL-1:0] elig;
            hit  = 1'b0;
            sel  = '0;
            idx  = '0;
            cand = '0;
            for (int u = 0; u < VC_TOTAL; u++) begin
                cand[u] = in_hit[u] && (in_sel[u] == PTR_SIZE'(gi));
            end
            elig = (|(cand & urgent)) ? (cand & urgent) : cand;
            for (int k = 0; k < VC_TOTAL; k++) begin
                idx = PTR_SIZE'((int'(out_ptr_reg[gi]) + k) % VC_TOTAL);
                if (!hit && elig[idx]) begin
                    hit = 1'b1;
                    sel = idx;
                end
            end
        end
        assign out_hit[gi] = hit;
        assign out_sel[gi] = sel;
    end

    // Fold the per-downstream winners back onto the requesters.
    always_comb begin
        gnt_valid = '0;
        gnt_d     = '0;
        for (int d = 0; d < VC_TOTAL; d++) begin
            for (int u = 0; u < VC_TOTAL; u++) begin
                if (out_hit[d] && (out_sel[d] == PTR_SIZE'(u))) begin
                    gnt_valid[u] = 1'b1;
                    gnt_d[u]     = PTR_SIZE'(d);
                end
            end
        end
    end

    assign vc_valid_o     = rst ? '0 : gnt_valid;
    assign available_vc_o = avail_reg;

    for (genvar gi = 0; gi < VC_TOTAL; gi++) begin : g_vc_new
        assign vc_new_o[gi] = vc_valid_o[gi]
                            ? VC_SIZE'(int'(gnt_d[gi]) % VC_NUM) : '0;
    end

    always_comb begin
        avail_next   = avail_reg;
        in_ptr_next  = in_ptr_reg;
        out_ptr_next = out_ptr_reg;
        age_next     = age_reg;
        // A granted VC is always available, so grant and release are exclusive.
        for (int d = 0; d < VC_TOTAL; d++) begin
            if (out_hit[d]) begin
                avail_next[d]   = 1'b0;
                out_ptr_next[d] = PTR_SIZE'((int'(out_sel[d]) + 1) % VC_TOTAL);
            end else if (!avail_reg[d] && idle_downstream_vc_i[d]) begin
                avail_next[d] = 1'b1;
            end
        end
        for (int u = 0; u < VC_TOTAL; u++) begin
            if (vc_valid_o[u]) begin
                in_ptr_next[u] = PTR_SIZE'((int'(gnt_d[u]) + 1) % VC_TOTAL);
            end
            if (vc_valid_o[u] || !vc_to_allocate_i[u]) begin
                age_next[u] = '0;
            end else if (age_reg[u] != AGE_URGENT) begin
                age_next[u] = age_reg[u] + AGE_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avail_reg   <= '1;
            in_ptr_reg  <= '0;
            out_ptr_reg <= '0;
            age_reg     <= '0;
        end else begin
            avail_reg   <= avail_next;
            in_ptr_reg  <= in_ptr_next;
            out_ptr_reg <= out_ptr_next;
            age_reg     <= age_next;
        end
    end

endmodule

// File: tb/tb_vc_class_allocator.sv
// Scoreboard bench for vc_class_allocator: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_vc_class_allocator;

    localparam int PN = 5, VN = 4, CN = 2, AM = 3;
    localparam int T = PN * VN, PS = 3, CS = 1, VS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [T-1:0]          idle, req;
    logic [T-1:0][PS-1:0]  port;
    logic [T-1:0][CS-1:0]  cls;
    logic [T-1:0][VS-1:0]  vnew;
    logic [T-1:0]          vvalid, avail;

    vc_class_allocator #(
        .PORT_NUM(PN), .VC_NUM(VN), .CLASS_NUM(CN), .AGE_MAX(AM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .idle_downstream_vc_i(idle),
        .vc_to_allocate_i(req),
        .out_port_i(port),
        .vc_class_i(cls),
        .vc_new_o(vnew),
        .vc_valid_o(vvalid),
        .available_vc_o(avail)
    );

    typedef struct {
        int                   cyc;
        logic [T-1:0]         valid;
        logic [T-1:0][VS-1:0] vnew;
        logic [T-1:0]         avail;
    } exp_t;

    // kind: 0 whole vc_valid_o, 1 vc_new_o[idx], 2 available_vc_o[idx], 3 whole available_vc_o
    typedef struct {
        int    cyc;
        int    kind;
        int    idx;
        int    val;
        string name;
    } pchk_t;

    exp_t  exp_q[$];
    pchk_t pc_q[$];
    int checks = 0, failures = 0, cyc = 0;

    int m_avail[T], m_in_ptr[T], m_out_ptr[T], m_age[T];

    task automatic m_reset();
        for (int i = 0; i < T; i++) begin
            m_avail[i] = 1; m_in_ptr[i] = 0; m_out_ptr[i] = 0; m_age[i] = 0;
        end
    endtask

    // Reference model: evaluates the allocation for the current inputs, then advances state.
    task automatic model(output logic [T-1:0] ev, output logic [T-1:0][VS-1:0] en);
        int sel[T]; int win[T]; int gd[T];
        int d, u;
        bit urg;
        ev = '0; en = '0;
        if (rst) begin
            m_reset();
            return;
        end
        for (int a = 0; a < T; a++) begin
            sel[a] = -1;
            if (req[a]) begin
                for (int k = 0; k < T; k++) begin
                    d = (m_in_ptr[a] + k) % T;
                    if (m_avail[d] != 0 && d / VN == int'(port[a])
                        && (d % VN) / (VN / CN) == int'(cls[a])) begin
                        sel[a] = d;
                        break;
                    end
                end
            end
        end
        for (int b = 0; b < T; b++) begin
            urg = 0;
            for (int a = 0; a < T; a++) if (sel[a] == b && m_age[a] == AM) urg = 1;
            win[b] = -1;
            for (int k = 0; k < T; k++) begin
                u = (m_out_ptr[b] + k) % T;
                if (sel[u] == b && (!urg || m_age[u] == AM)) begin
                    win[b] = u;
                    break;
                end
            end
        end
        for (int a = 0; a < T; a++) gd[a] = -1;
        for (int b = 0; b < T; b++) if (win[b] >= 0) gd[win[b]] = b;
        for (int a = 0; a < T; a++) begin
            if (gd[a] >= 0) begin
                ev[a] = 1'b1;
                en[a] = VS'(gd[a] % VN);
            end
        end
        for (int b = 0; b < T; b++) begin
            if (win[b] >= 0) begin
                m_avail[b] = 0;
                m_out_ptr[b] = (win[b] + 1) % T;
            end else if (m_avail[b] == 0 && idle[b]) begin
                m_avail[b] = 1;
            end
        end
        for (int a = 0; a < T; a++) begin
            if (gd[a] >= 0) m_in_ptr[a] = (gd[a] + 1) % T;
            if (gd[a] >= 0 || !req[a]) m_age[a] = 0;
            else if (m_age[a] < AM) m_age[a] = m_age[a] + 1;
        end
    endtask

    task automatic step();
        exp_t e;
        logic [T-1:0] ev;
        logic [T-1:0][VS-1:0] en;
        for (int d = 0; d < T; d++) e.avail[d] = (m_avail[d] != 0);
        model(ev, en);
        e.cyc = cyc; e.valid = ev; e.vnew = en;
        exp_q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic pc(input string nm, input int kind, input int idx, input int val);
        pchk_t p;
        p.cyc = cyc; p.kind = kind; p.idx = idx; p.val = val; p.name = nm;
        pc_q.push_back(p);
    endtask

    task automatic clr();
        req = '0; port = '0; cls = '0; idle = '0; rst = 1'b0;
    endtask

    task automatic set_req(input int u, input int p, input int c);
        req[u] = 1'b1; port[u] = PS'(p); cls[u] = CS'(c);
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Two busy port-1 class-0 VCs: u0 takes d4, then u1 takes d5.
    task automatic fill_p1c0();
        set_req(0, 1, 0); set_req(1, 1, 0);
        pc("fill_u0", 0, 0, 'h1); step();
        req[0] = 1'b0;
        pc("fill_u1", 0, 0, 'h2); step();
    endtask

    always @(negedge clk) begin
        exp_t  e;
        pchk_t p;
        int    act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (vvalid !== e.valid) begin
                failures++;
                $display("FAIL vc_valid cyc=%0d got=%h exp=%h", e.cyc, vvalid, e.valid);
            end
            checks++;
            if (vnew !== e.vnew) begin
                failures++;
                $display("FAIL vc_new cyc=%0d got=%h exp=%h", e.cyc, vnew, e.vnew);
            end
            checks++;
            if (avail !== e.avail) begin
                failures++;
                $display("FAIL avail cyc=%0d got=%h exp=%h", e.cyc, avail, e.avail);
            end
            $display("cyc=%0d req=%h valid=%h new=%h avail=%h", e.cyc, req, vvalid, vnew, avail);
            while (pc_q.size() > 0 && pc_q[0].cyc == e.cyc) begin
                p = pc_q.pop_front();
                case (p.kind)
                    0:       act = int'(vvalid);
                    1:       act = int'(vnew[p.idx]);
                    2:       act = int'(avail[p.idx]);
                    default: act = int'(avail);
                endcase
                checks++;
                if (act != p.val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", p.name, e.cyc, act, p.val);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rst = 1'b0;
        pc("reset_valid", 0, 0, 0);
        pc("reset_avail", 3, 0, 'hFFFFF);
        step();

        // All requesters target port 1 class 0
        do_reset();
        for (int u = 0; u < T; u++) set_req(u, 1, 0);
        pc("all_first_valid", 0, 0, 'h1); pc("all_first_new0", 1, 0, 0); step();
        req[0] = 1'b0;
        pc("all_second_valid", 0, 0, 'h2); pc("all_second_new1", 1, 1, 1); step();
        req[1] = 1'b0;
        pc("all_third_valid", 0, 0, 0); pc("all_av4", 2, 4, 0); pc("all_av5", 2, 5, 0); step();

        // Single request to port 2 class 1
        do_reset();
        set_req(3, 2, 1);
        pc("u3_valid", 0, 0, 'h8); pc("u3_new", 1, 3, 2); step();
        clr();
        pc("u3_av10", 2, 10, 0); step();

        // Release of d4 serves a waiting requester the next cycle
        do_reset();
        fill_p1c0();
        req[1] = 1'b0; set_req(2, 1, 0); idle[4] = 1'b1;
        pc("rel_wait_valid", 0, 0, 0); step();
        idle[4] = 1'b0;
        pc("rel_av4", 2, 4, 1); pc("rel_valid", 0, 0, 'h4); pc("rel_new2", 1, 2, 0); step();

        // Urgent u7 beats u9 although out_ptr[4] points at u9
        do_reset();
        fill_p1c0();
        clr(); idle[4] = 1'b1; step();
        clr(); set_req(8, 1, 0);
        pc("urg_u8_valid", 0, 0, 'h100); step();
        clr(); set_req(7, 1, 0);
        pc("urg_lose1", 0, 0, 0); step();
        pc("urg_lose2", 0, 0, 0); step();
        idle[4] = 1'b1;
        pc("urg_lose3", 0, 0, 0); step();
        idle[4] = 1'b0; set_req(9, 1, 0);
        pc("urg_valid", 0, 0, 'h80); pc("urg_new7", 1, 7, 0); step();

        // Dropping the request clears the age, so u7 is not urgent later
        do_reset();
        fill_p1c0();
        clr(); idle[4] = 1'b1; step();
        clr(); set_req(8, 1, 0);
        pc("age_u8_valid", 0, 0, 'h100); step();
        clr(); set_req(7, 1, 0);
        step(); step();
        req[7] = 1'b0; step();
        req[7] = 1'b1; step();
        idle[4] = 1'b1; step();
        idle[4] = 1'b0; set_req(9, 1, 0);
        pc("age_valid", 0, 0, 'h200); pc("age_new9", 1, 9, 0); step();

        // Reset mid-operation with busy VCs and live requests
        do_reset();
        set_req(0, 1, 0); set_req(1, 1, 0); set_req(3, 2, 1);
        pc("mid_valid1", 0, 0, 'h9); step();
        req[0] = 1'b0; req[3] = 1'b0;
        pc("mid_valid2", 0, 0, 'h2); step();
        set_req(2, 1, 0); set_req(4, 1, 0); set_req(5, 1, 0); set_req(6, 2, 1);
        rst = 1'b1;
        pc("mid_rst_valid1", 0, 0, 0); step();
        pc("mid_rst_valid2", 0, 0, 0); step();
        clr();
        pc("mid_avail", 3, 0, 'hFFFFF); step();

        // Randomized traffic including out-of-range ports and sporadic resets
        for (int n = 0; n < 1500; n++) begin
            for (int u = 0; u < T; u++) begin
                req[u]  = ($urandom % 10) < 6;
                port[u] = PS'($urandom_range(0, 6));
                cls[u]  = CS'($urandom % 2);
                idle[u] = ($urandom % 4) == 0;
            end
            rst = ($urandom % 150) == 0;
            step();
        end

        clr();
        step();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || pc_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size() + pc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
